// File: rtl/biquad_mac_datapath.sv
// Biquad IIR arithmetic datapath: sample/coefficient storage, one registered
// multiplier, one accumulator and a saturating output register. Sequencing
// comes entirely from the external filter controller (one sample per 7-cycle frame).
module biquad_mac_datapath #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int FRAC_BITS = 14,
    parameter int ACC_W     = 40
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     coef_wr_en,
    input  logic [2:0]               coef_wr_addr,
    input  logic signed [COEF_W-1:0] coef_wr_data,
    input  logic [1:0]               sel_x_y,
    input  logic [1:0]               x_mem_dir,
    input  logic [1:0]               y_mem_dir,
    input  logic [2:0]               coef_dir,
    input  logic                     mult_enable,
    input  logic                     acc_enable,
    input  logic                     acc_reset,
    input  logic                     output_reg_enable,
    output logic signed [DATA_W-1:0] y_out,
    output logic                     y_valid,
    output logic                     sat_flag,
    output logic                     underrun_flag
);

    localparam int PROD_W   = DATA_W + COEF_W;
    localparam int NUM_COEF = 5;

    localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1 << FRAC_BITS);
    localparam logic signed [ACC_W-1:0]  Y_MAX    =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  Y_MIN    =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic signed [DATA_W-1:0] x0_q, x0_d;
    logic signed [DATA_W-1:0] xh1_q, xh1_d, xh2_q, xh2_d;
    logic signed [DATA_W-1:0] yh1_q, yh1_d, yh2_q, yh2_d;
    logic signed [DATA_W-1:0] y_out_q, y_out_d;
    logic                     y_valid_q, y_valid_d;
    logic                     sat_q, sat_d;
    logic                     underrun_q, underrun_d;
    logic signed [COEF_W-1:0] coef_q [NUM_COEF];
    logic signed [COEF_W-1:0] coef_d [NUM_COEF];

    logic signed [DATA_W-1:0] x_hist, y_hist, operand;
    logic signed [COEF_W-1:0] coef_rd;
    logic signed [ACC_W-1:0]  prod_ext, acc_sum, out_shift;
    logic signed [DATA_W-1:0] y_sat;
    logic                     clip_hi, clip_lo;

    // Operand and coefficient selection; undefined codes read zero
    always_comb begin
        x_hist = '0;
        case (x_mem_dir)
            2'd0:    x_hist = xh1_q;
            2'd1:    x_hist = xh2_q;
            default: x_hist = '0;
        endcase

        y_hist = '0;
        case (y_mem_dir)
            2'd0:    y_hist = yh1_q;
            2'd1:    y_hist = yh2_q;
            default: y_hist = '0;
        endcase

        operand = '0;
        case (sel_x_y)
            2'd0:    operand = x0_q;
            2'd1:    operand = x_hist;
            2'd2:    operand = y_hist;
            default: operand = '0;
        endcase

        coef_rd = '0;
        case (coef_dir)
            3'd0:    coef_rd = coef_q[0];
            3'd1:    coef_rd = coef_q[1];
            3'd2:    coef_rd = coef_q[2];
            3'd3:    coef_rd = coef_q[3];
            3'd4:    coef_rd = coef_q[4];
            default: coef_rd = '0;
        endcase
    end

    // Running sum and saturating requantisation of the finished frame
    always_comb begin
        prod_ext  = ACC_W'(prod_q);
        acc_sum   = acc_q + prod_ext;
        out_shift = acc_sum >>> FRAC_BITS;
        clip_hi   = out_shift > Y_MAX;
        clip_lo   = out_shift < Y_MIN;
        if (clip_hi) begin
            y_sat = Y_MAX[DATA_W-1:0];
        end else if (clip_lo) begin
            y_sat = Y_MIN[DATA_W-1:0];
        end else begin
            y_sat = out_shift[DATA_W-1:0];
        end
    end

    // Next-state for all datapath registers
    always_comb begin
        acc_d      = acc_q;
        prod_d     = prod_q;
        x0_d       = x0_q;
        xh1_d      = xh1_q;
        xh2_d      = xh2_q;
        yh1_d      = yh1_q;
        yh2_d      = yh2_q;
        y_out_d    = y_out_q;
        y_valid_d  = output_reg_enable;
        sat_d      = sat_q;
        underrun_d = underrun_q;

        for (int unsigned i = 0; i < NUM_COEF; i++) begin
            coef_d[i] = (coef_wr_en && coef_wr_addr == 3'(i)) ? coef_wr_data : coef_q[i];
        end

        if (mult_enable) begin
            prod_d = PROD_W'(operand) * PROD_W'(coef_rd);
        end

        if (acc_reset) begin
            acc_d = '0;
        end else if (acc_enable) begin
            acc_d = acc_sum;
        end

        if (acc_reset) begin
            if (in_valid) begin
                x0_d = sample_in;
            end else begin
                underrun_d = 1'b1;
            end
        end

        // History shift uses the pre-capture x0, so a coincident acc_reset
        // still finalises the old frame before the new sample lands.
        if (output_reg_enable) begin
            y_out_d = y_sat;
            yh1_d   = y_sat;
            yh2_d   = yh1_q;
            xh1_d   = x0_q;
            xh2_d   = xh1_q;
            if (clip_hi || clip_lo) begin
                sat_d = 1'b1;
            end
        end
    end

    // Register update; reset restores pass-through coefficients
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q      <= '0;
            prod_q     <= '0;
            x0_q       <= '0;
            xh1_q      <= '0;
            xh2_q      <= '0;
            yh1_q      <= '0;
            yh2_q      <= '0;
            y_out_q    <= '0;
            y_valid_q  <= 1'b0;
            sat_q      <= 1'b0;
            underrun_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_COEF; i++) begin
                coef_q[i] <= (i == 0) ? COEF_ONE : '0;
            end
        end else begin
            acc_q      <= acc_d;
            prod_q     <= prod_d;
            x0_q       <= x0_d;
            xh1_q      <= xh1_d;
            xh2_q      <= xh2_d;
            yh1_q      <= yh1_d;
            yh2_q      <= yh2_d;
            y_out_q    <= y_out_d;
            y_valid_q  <= y_valid_d;
            sat_q      <= sat_d;
            underrun_q <= underrun_d;
            coef_q     <= coef_d;
        end
    end

    assign in_ready      = acc_reset;
    assign y_out         = y_out_q;
    assign y_valid       = y_valid_q;
    assign sat_flag      = sat_q;
    assign underrun_flag = underrun_q;

endmodule
